// File: rtl/riscv_shift_pkg.sv
// Shared encodings for the RISC-V shifters: operation type, iterative-shifter
// state and the set of supported per-cycle shift widths.
package riscv_shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_SRL  = 2'b00,
      SHIFT_SLL  = 2'b01,
      SHIFT_SRA  = 2'b10,
      SHIFT_PASS = 2'b11
   } shift_type_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } shift_state_e;

   localparam int unsigned NUM_LEGAL_SPC = 4;
   localparam int unsigned LEGAL_SPC [NUM_LEGAL_SPC] = '{32'd1, 32'd2, 32'd4, 32'd8};

   function automatic bit spcIsLegal(input int unsigned spc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < int'(NUM_LEGAL_SPC); i++) begin
         if (LEGAL_SPC[i] == spc) begin
            ok = 1'b1;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the serial shifter: shifts the accumulator by a small
// amount according to the operation type; pass-through leaves it untouched.
module shift_step
   import riscv_shift_pkg::*;
(
   input  logic [31:0]  acc_i,
   input  logic [4:0]   step_i,
   input  shift_type_e  typ_i,
   output logic [31:0]  acc_o
);

   always_comb begin
      acc_o = acc_i;
      case (typ_i)
         SHIFT_SRL: acc_o = acc_i >> step_i;
         SHIFT_SLL: acc_o = acc_i << step_i;
         SHIFT_SRA: acc_o = $signed(acc_i) >>> step_i;
         default:   acc_o = acc_i;
      endcase
   end

endmodule

// File: rtl/serial_shift_unit.sv
// Area-lean iterative shifter for the EX stage: accepts a request via
// start/done, shifts up to SHIFT_PER_CYCLE bits per clock and stalls the pipe.
module serial_shift_unit
   import riscv_shift_pkg::*;
#(
   parameter int unsigned SHIFT_PER_CYCLE = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         flush_i,
   input  logic [31:0]  a_i,
   input  logic [4:0]   shamt_i,
   input  logic [1:0]   type_i,
   output logic [31:0]  r_o,
   output logic         done_o,
   output logic         busy_o,
   output logic         stall_o
);

   if (!spcIsLegal(SHIFT_PER_CYCLE)) begin : gBadSpc
      $error("serial_shift_unit: SHIFT_PER_CYCLE must be 1, 2, 4 or 8");
   end

   localparam logic [4:0] SPC = 5'(SHIFT_PER_CYCLE);

   shift_state_e  state_q;
   shift_type_e   typ_q;
   logic [31:0]   acc_q;
   logic [31:0]   acc_d;
   logic [4:0]    cnt_q;
   logic [4:0]    cnt_d;
   logic [4:0]    stepAmt;
   logic [31:0]   r_q;
   logic          done_q;
   logic          busy_q;
   logic          inShift;
   logic          accept;
   logic          zeroWork;

   assign inShift  = (state_q == ST_SHIFT);
   assign accept   = start_i && !flush_i && !inShift;
   assign zeroWork = (shamt_i == 5'd0) || (type_i == SHIFT_PASS);

   // The last iteration only consumes what is left of the shift amount.
   assign stepAmt = (cnt_q < SPC) ? cnt_q : SPC;
   assign cnt_d   = cnt_q - stepAmt;

   shift_step uStep (
      .acc_i  (acc_q),
      .step_i (stepAmt),
      .typ_i  (typ_q),
      .acc_o  (acc_d)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         typ_q   <= SHIFT_SRL;
         acc_q   <= '0;
         cnt_q   <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_SHIFT: begin
               if (flush_i) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_d;
                  if (cnt_d == 5'd0) begin
                     r_q     <= acc_d;
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            // IDLE and DONE both accept, which allows back-to-back issue.
            default: begin
               if (accept) begin
                  acc_q <= a_i;
                  cnt_q <= shamt_i;
                  typ_q <= shift_type_e'(type_i);
                  if (zeroWork) begin
                     r_q     <= a_i;
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_SHIFT;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign r_o     = r_q;
   assign done_o  = done_q;
   assign busy_o  = busy_q;
   assign stall_o = inShift || (accept && !zeroWork);

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit at SHIFT_PER_CYCLE 1 and 4, checked
// against a result/latency model and hand-computed expectations.
module tb_serial_shift_unit;

   localparam int SPC_OF [2] = '{1, 4};

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        startI = 1'b0;
   logic        flushI = 1'b0;
   logic [31:0] aI = '0;
   logic [4:0]  shamtI = '0;
   logic [1:0]  typeI = '0;

   logic [31:0] rOut [2];
   logic        doneOut [2];
   logic        busyOut [2];
   logic        stallOut [2];

   int checks = 0;
   int errors = 0;

   int          mLeft [2] = '{0, 0};
   logic [31:0] mPend [2] = '{32'd0, 32'd0};
   logic [31:0] mR [2]    = '{32'd0, 32'd0};
   logic        mDone [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   serial_shift_unit #(.SHIFT_PER_CYCLE(1)) dut1 (
      .clk_i(clk), .rst_ni(rstN), .start_i(startI), .flush_i(flushI),
      .a_i(aI), .shamt_i(shamtI), .type_i(typeI),
      .r_o(rOut[0]), .done_o(doneOut[0]), .busy_o(busyOut[0]), .stall_o(stallOut[0])
   );

   serial_shift_unit #(.SHIFT_PER_CYCLE(4)) dut4 (
      .clk_i(clk), .rst_ni(rstN), .start_i(startI), .flush_i(flushI),
      .a_i(aI), .shamt_i(shamtI), .type_i(typeI),
      .r_o(rOut[1]), .done_o(doneOut[1]), .busy_o(busyOut[1]), .stall_o(stallOut[1])
   );

   // Reference result of a single full-width shift.
   function automatic logic [31:0] refShift(input logic [31:0] a, input int sh, input logic [1:0] ty);
      case (ty)
         2'b00:   return a >> sh;
         2'b01:   return a << sh;
         2'b10:   return a[31] ? ~((~a) >> sh) : (a >> sh);
         default: return a;
      endcase
   endfunction

   // Model: a request finishes ceil(shamt/spc) edges after acceptance with the full-shift result.
   always @(posedge clk or negedge rstN) begin
      for (int k = 0; k < 2; k++) begin
         if (!rstN) begin
            mLeft[k] <= 0;
            mPend[k] <= '0;
            mR[k]    <= '0;
            mDone[k] <= 1'b0;
         end else begin
            mDone[k] <= 1'b0;
            if (mLeft[k] > 0) begin
               if (flushI) begin
                  mLeft[k] <= 0;
               end else begin
                  mLeft[k] <= mLeft[k] - 1;
                  if (mLeft[k] == 1) begin
                     mR[k]    <= mPend[k];
                     mDone[k] <= 1'b1;
                  end
               end
            end else if (startI && !flushI) begin
               if (shamtI == 5'd0 || typeI == 2'b11) begin
                  mR[k]    <= refShift(aI, int'(shamtI), typeI);
                  mDone[k] <= 1'b1;
               end else begin
                  mLeft[k] <= (int'(shamtI) + SPC_OF[k] - 1) / SPC_OF[k];
                  mPend[k] <= refShift(aI, int'(shamtI), typeI);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, compare both DUTs against the model.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("model r[%0d]", k), rOut[k], mR[k]);
         checkOutput($sformatf("model done[%0d]", k), 32'(doneOut[k]), 32'(mDone[k]));
         checkOutput($sformatf("model busy[%0d]", k), 32'(busyOut[k]), 32'(mLeft[k] > 0));
         checkOutput($sformatf("model stall[%0d]", k), 32'(stallOut[k]),
                     32'((mLeft[k] > 0) || (startI && !flushI && shamtI != 5'd0 && typeI != 2'b11)));
      end
   end

   task automatic applyStimulus(input logic s, input logic f, input logic [31:0] a,
                                input logic [4:0] sh, input logic [1:0] ty);
      startI = s;
      flushI = f;
      aI     = a;
      shamtI = sh;
      typeI  = ty;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic issueOp(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] ty);
      applyStimulus(1'b1, 1'b0, a, sh, ty);
      stepCycle();
      applyStimulus(1'b0, 1'b0, a, sh, ty);
   endtask

   task automatic waitBoth(input int already, output int lat0, output int lat1,
                           output logic [31:0] res0, output logic [31:0] res1);
      int cyc;
      bit seen0;
      bit seen1;
      cyc = already;
      seen0 = 1'b0;
      seen1 = 1'b0;
      lat0 = -1;
      lat1 = -1;
      res0 = '0;
      res1 = '0;
      for (int n = 0; n < 64 && !(seen0 && seen1); n++) begin
         if (!seen0 && doneOut[0]) begin seen0 = 1'b1; lat0 = cyc; res0 = rOut[0]; end
         if (!seen1 && doneOut[1]) begin seen1 = 1'b1; lat1 = cyc; res1 = rOut[1]; end
         if (!(seen0 && seen1)) begin
            stepCycle();
            cyc++;
         end
      end
   endtask

   task automatic checkOp(input string name, input int lat0, input int lat1,
                          input logic [31:0] res0, input logic [31:0] res1,
                          input int expLat0, input int expLat1, input logic [31:0] expR);
      checkOutput({name, " latency spc1"}, 32'(lat0), 32'(expLat0));
      checkOutput({name, " latency spc4"}, 32'(lat1), 32'(expLat1));
      checkOutput({name, " r spc1"}, res0, expR);
      checkOutput({name, " r spc4"}, res1, expR);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int l0, l1, doneCount;
      logic [31:0] v0, v1;

      applyStimulus(1'b0, 1'b0, '0, '0, 2'b00);
      #1;
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("reset r[%0d]", k), rOut[k], 32'h0);
         checkOutput($sformatf("reset busy[%0d]", k), 32'(busyOut[k]), 32'h0);
         checkOutput($sformatf("reset done[%0d]", k), 32'(doneOut[k]), 32'h0);
      end
      @(posedge clk);
      @(posedge clk);
      #3 rstN = 1'b1;
      stepCycle();

      // SRA keeps sign through every iteration.
      applyStimulus(1'b1, 1'b0, 32'h8000_0000, 5'd4, 2'b10);
      #1 checkOutput("sra request stall", 32'(stallOut[0]), 32'h1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 32'h8000_0000, 5'd4, 2'b10);
      checkOutput("sra shifting stall", 32'(stallOut[0]), 32'h1);
      waitBoth(0, l0, l1, v0, v1);
      checkOp("sra4", l0, l1, v0, v1, 4, 1, 32'hF800_0000);

      issueOp(32'h0000_0001, 5'd31, 2'b01);
      waitBoth(0, l0, l1, v0, v1);
      checkOp("sll31", l0, l1, v0, v1, 31, 8, 32'h8000_0000);

      issueOp(32'h8000_0000, 5'd31, 2'b00);
      waitBoth(0, l0, l1, v0, v1);
      checkOp("srl31", l0, l1, v0, v1, 31, 8, 32'h0000_0001);
      stepCycle();

      // Zero-work requests back to back.
      applyStimulus(1'b1, 1'b0, 32'h1234_5678, 5'd0, 2'b00);
      #1 checkOutput("zero shamt stall", 32'(stallOut[0]), 32'h0);
      stepCycle();
      checkOutput("zero shamt done", 32'(doneOut[1]), 32'h1);
      checkOutput("zero shamt r", rOut[1], 32'h1234_5678);
      applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 5'd5, 2'b11);
      #1 checkOutput("pass stall", 32'(stallOut[1]), 32'h0);
      stepCycle();
      checkOutput("pass done", 32'(doneOut[0]), 32'h1);
      checkOutput("pass r", rOut[0], 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b0, '0, '0, 2'b00);
      stepCycle();
      checkOutput("pass done clears", 32'(doneOut[0]), 32'h0);

      // Start during SHIFT is ignored.
      issueOp(32'hFFFF_FFFF, 5'd8, 2'b00);
      applyStimulus(1'b1, 1'b0, 32'h0, 5'd5, 2'b01);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
      waitBoth(1, l0, l1, v0, v1);
      checkOp("srl8 ignore start", l0, l1, v0, v1, 8, 2, 32'h00FF_FFFF);
      stepCycle();

      // Flush after three iterations abandons the shift.
      issueOp(32'h0000_000F, 5'd20, 2'b01);
      repeat (3) stepCycle();
      applyStimulus(1'b0, 1'b1, 32'h0000_000F, 5'd20, 2'b01);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("flush busy[%0d]", k), 32'(busyOut[k]), 32'h0);
         checkOutput($sformatf("flush stall[%0d]", k), 32'(stallOut[k]), 32'h0);
         checkOutput($sformatf("flush r[%0d]", k), rOut[k], 32'h00FF_FFFF);
      end
      doneCount = 0;
      for (int n = 0; n < 24; n++) begin
         if (doneOut[0] || doneOut[1]) doneCount++;
         stepCycle();
      end
      checkOutput("flush no done", 32'(doneCount), 32'h0);

      // Asynchronous reset mid-shift.
      issueOp(32'h8000_0000, 5'd16, 2'b10);
      repeat (2) stepCycle();
      #2 rstN = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("async reset r[%0d]", k), rOut[k], 32'h0);
         checkOutput($sformatf("async reset busy[%0d]", k), 32'(busyOut[k]), 32'h0);
         checkOutput($sformatf("async reset stall[%0d]", k), 32'(stallOut[k]), 32'h0);
      end
      @(posedge clk);
      #3 rstN = 1'b1;
      stepCycle();
      issueOp(32'hF000_0000, 5'd4, 2'b00);
      waitBoth(0, l0, l1, v0, v1);
      checkOp("post reset srl4", l0, l1, v0, v1, 4, 1, 32'h0F00_0000);

      repeat (3) stepCycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
